// File: rtl/dff_sync_pipe_if.sv
// Bus bundle for dff_sync_pipe: stall/flush controls, input sample, last-stage output and occupancy.
interface dff_sync_pipe_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 3
);
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  logic             en;
  logic             flush;
  logic [WIDTH-1:0] d;
  logic             d_vld;
  logic [WIDTH-1:0] q;
  logic             q_vld;
  logic [OCC_W-1:0] occ;

  modport master (output en, flush, d, d_vld, input q, q_vld, occ);
  modport slave  (input en, flush, d, d_vld, output q, q_vld, occ);
endinterface

// File: rtl/dff_sync_pipe.sv
// WIDTH-bit, DEPTH-stage retiming pipeline with per-stage valid, global stall,
// flush, programmable reset value and a running count of valid stages.
module dff_sync_pipe #(
  parameter int unsigned      WIDTH   = 8,
  parameter int unsigned      DEPTH   = 3,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic            clk,
  input  logic            sr,
  dff_sync_pipe_if.slave  pipe
);
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [DEPTH-1:0] vld_d;
  logic [OCC_W-1:0] occ_q;
  logic [OCC_W-1:0] occ_d;
  logic [OCC_W-1:0] vld_cnt_c;

  // Next state: flush clears, enable shifts data and valid together, otherwise hold.
  always_comb begin
    data_d = data_q;
    vld_d  = vld_q;
    occ_d  = occ_q;
    if (pipe.flush) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        data_d[i] = RST_VAL;
      end
      vld_d = '0;
      occ_d = '0;
    end else if (pipe.en) begin
      data_d[0] = pipe.d;
      vld_d[0]  = pipe.d_vld;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        data_d[i] = data_q[i-1];
        vld_d[i]  = vld_q[i-1];
      end
      occ_d = occ_q + OCC_W'(pipe.d_vld) - OCC_W'(vld_q[DEPTH-1]);
    end
  end

  always_ff @(posedge clk) begin
    if (sr) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        data_q[i] <= RST_VAL;
      end
      vld_q <= '0;
      occ_q <= '0;
    end else begin
      data_q <= data_d;
      vld_q  <= vld_d;
      occ_q  <= occ_d;
    end
  end

  assign pipe.q     = data_q[DEPTH-1];
  assign pipe.q_vld = vld_q[DEPTH-1];
  assign pipe.occ   = occ_q;

  // Incremental occupancy must always agree with the stage valids.
  always_comb begin
    vld_cnt_c = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      vld_cnt_c = vld_cnt_c + OCC_W'(vld_q[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!sr) begin
      assert (occ_q == vld_cnt_c);
    end
  end
endmodule

// File: tb/tb_dff_sync_pipe.sv
// Directed bench for dff_sync_pipe: DEPTH=3/WIDTH=8 main instance with a queue
// scoreboard, plus a DEPTH=1/WIDTH=1 instance for the single-stage corner.
module tb_dff_sync_pipe;
  typedef struct packed {
    logic [7:0] d;
    logic       v;
  } ent_t;

  logic clk;
  logic sr;
  logic sr1;
  int   checks;
  int   errors;
  ent_t sb[$];

  dff_sync_pipe_if #(.WIDTH(8), .DEPTH(3)) bus ();
  dff_sync_pipe_if #(.WIDTH(1), .DEPTH(1)) bus1 ();

  dff_sync_pipe #(.WIDTH(8), .DEPTH(3), .RST_VAL(8'hA5)) dut (
    .clk  (clk),
    .sr   (sr),
    .pipe (bus.slave)
  );

  dff_sync_pipe #(.WIDTH(1), .DEPTH(1), .RST_VAL(1'b0)) dut1 (
    .clk  (clk),
    .sr   (sr1),
    .pipe (bus1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference pipeline: front of queue is the output stage, back is stage 0.
  task automatic model_edge(input logic r, input logic f, input logic e,
                            input logic [7:0] dv, input logic v);
    ent_t n;
    if (r || f) begin
      sb.delete();
      for (int i = 0; i < 3; i++) sb.push_back({8'hA5, 1'b0});
    end else if (e) begin
      n.d = dv;
      n.v = v;
      void'(sb.pop_front());
      sb.push_back(n);
    end
  endtask

  // One clock edge on the main instance, then scoreboard compare of q/q_vld/occ.
  task automatic step(input string tag, input logic r, input logic f, input logic e,
                      input logic [7:0] dv, input logic v);
    int cnt;
    sr        = r;
    bus.flush = f;
    bus.en    = e;
    bus.d     = dv;
    bus.d_vld = v;
    @(posedge clk);
    #1;
    model_edge(r, f, e, dv, v);
    cnt = 0;
    foreach (sb[i]) cnt += int'(sb[i].v);
    chk({tag, ".q"},     bus.q,            sb[0].d);
    chk({tag, ".q_vld"}, 8'(bus.q_vld),    8'(sb[0].v));
    chk({tag, ".occ"},   8'(bus.occ),      8'(cnt));
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    sr        = 1'b1;
    sr1       = 1'b1;
    bus.en    = 1'b1;
    bus.flush = 1'b0;
    bus.d     = 8'hFF;
    bus.d_vld = 1'b1;
    bus1.en   = 1'b1;
    bus1.flush = 1'b0;
    bus1.d    = 1'b1;
    bus1.d_vld = 1'b1;

    // Reset edge with active inputs
    step("rst", 1'b1, 1'b0, 1'b1, 8'hFF, 1'b1);
    chk("rst.q_const", bus.q, 8'hA5);
    chk("rst.occ_const", 8'(bus.occ), 8'd0);

    // Fill and drain
    step("fill1", 1'b0, 1'b0, 1'b1, 8'h11, 1'b1);
    step("fill2", 1'b0, 1'b0, 1'b1, 8'h22, 1'b1);
    step("fill3", 1'b0, 1'b0, 1'b1, 8'h33, 1'b1);
    chk("fill3.q_const", bus.q, 8'h11);
    chk("fill3.occ_const", 8'(bus.occ), 8'd3);
    step("drain1", 1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
    chk("drain1.q_const", bus.q, 8'h22);
    step("drain2", 1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
    chk("drain2.q_const", bus.q, 8'h33);
    step("drain3", 1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
    chk("drain3.occ_const", 8'(bus.occ), 8'd0);

    // Stall in the middle of a stream; stalled inputs must be dropped
    step("st1", 1'b0, 1'b0, 1'b1, 8'h01, 1'b1);
    step("st2", 1'b0, 1'b0, 1'b1, 8'h02, 1'b1);
    step("hold1", 1'b0, 1'b0, 1'b0, 8'hEE, 1'b1);
    step("hold2", 1'b0, 1'b0, 1'b0, 8'hEF, 1'b1);
    chk("hold2.occ_const", 8'(bus.occ), 8'd2);
    step("st3", 1'b0, 1'b0, 1'b1, 8'h03, 1'b1);
    chk("st3.q_const", bus.q, 8'h01);
    step("st4", 1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
    step("st5", 1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
    chk("st5.q_const", bus.q, 8'h03);

    // Flush a full pipe while pushing
    step("ff1", 1'b0, 1'b0, 1'b1, 8'h41, 1'b1);
    step("ff2", 1'b0, 1'b0, 1'b1, 8'h42, 1'b1);
    step("ff3", 1'b0, 1'b0, 1'b1, 8'h43, 1'b1);
    step("flush", 1'b0, 1'b1, 1'b1, 8'h44, 1'b1);
    chk("flush.q_vld_const", 8'(bus.q_vld), 8'd0);
    step("postfl", 1'b0, 1'b0, 1'b0, 8'h45, 1'b1);

    // Bubbles
    step("bub1", 1'b0, 1'b0, 1'b1, 8'hAA, 1'b1);
    step("bub2", 1'b0, 1'b0, 1'b1, 8'hBB, 1'b0);
    step("bub3", 1'b0, 1'b0, 1'b1, 8'hCC, 1'b1);
    chk("bub3.q_const", bus.q, 8'hAA);
    step("bub4", 1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
    chk("bub4.q_vld_const", 8'(bus.q_vld), 8'd0);
    step("bub5", 1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
    chk("bub5.q_const", bus.q, 8'hCC);
    chk("bub5.occ_const", 8'(bus.occ), 8'd1);

    // Reset mid-stream with en=1
    step("mid1", 1'b0, 1'b0, 1'b1, 8'h77, 1'b1);
    step("midrst", 1'b1, 1'b0, 1'b1, 8'h78, 1'b1);
    step("after", 1'b0, 1'b0, 1'b1, 8'h79, 1'b1);

    // Single-stage instance
    sr1 = 1'b0;
    bus1.d = 1'b1;
    bus1.d_vld = 1'b1;
    @(posedge clk); #1;
    chk("d1.q", 8'(bus1.q), 8'd1);
    chk("d1.q_vld", 8'(bus1.q_vld), 8'd1);
    chk("d1.occ", 8'(bus1.occ), 8'd1);
    bus1.d = 1'b0;
    bus1.d_vld = 1'b0;
    @(posedge clk); #1;
    chk("d1.bubble_occ", 8'(bus1.occ), 8'd0);
    bus1.d = 1'b1;
    bus1.d_vld = 1'b1;
    @(posedge clk); #1;
    chk("d1.reload_q", 8'(bus1.q), 8'd1);
    sr1 = 1'b1;
    @(posedge clk); #1;
    chk("d1.rst_q", 8'(bus1.q), 8'd0);
    chk("d1.rst_q_vld", 8'(bus1.q_vld), 8'd0);
    chk("d1.rst_occ", 8'(bus1.occ), 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
